// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// Shared PS/2 link definitions: host-TX FSM encodings, frame length, command bytes.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
`timescale 1ns/1ps
// PS/2 pad conditioning: 2-FF sync on clock and data, FILT_LEN-sample glitch filter on clock,
// one-cycle pulse on each filtered falling edge. Shared by the host transmitter and keyboard receiver.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_filt,
  output logic dat_sync,
  output logic clk_fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic [CW-1:0] run_cnt;

  // Idle bus level is high, so the synchronisers and filter reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt   <= 1'b1;
      run_cnt    <= '0;
      clk_fall   <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      clk_fall   <= 1'b0;
      if (clk_sync_q[1] == clk_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILT_LEN - 1)) begin
        clk_filt <= clk_sync_q[1];
        run_cnt  <= '0;
        clk_fall <= clk_filt;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign dat_sync = dat_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the device, ACK check.
// One byte per request; tx_ready only in IDLE, requests while busy are dropped.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILT_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYCLES - 1);
  localparam logic [19:0] TO_LAST    = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  STOP_FALL  = 4'(FRAME_BITS - 2);

  logic        clk_filt;
  logic        dat_sync;
  logic        clk_fall;
  logic [2:0]  state;
  logic [19:0] cyc_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift_q;
  logic        dat_oe_q;
  logic        accept;
  logic        in_timed;
  logic        timed_out;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_line_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_filt   (clk_filt),
    .dat_sync   (dat_sync),
    .clk_fall   (clk_fall)
  );

  // Holding tx_ready low during a result pulse keeps it from overlapping the next accept.
  assign tx_ready   = (state == ST_IDLE) & ~(done | ack_err | timeout_err);
  assign busy       = (state != ST_IDLE);
  assign accept     = tx_valid & tx_ready;
  assign ps2_clk_oe = (state == ST_INHIBIT) | (state == ST_REQ);
  assign ps2_dat_oe = dat_oe_q;
  assign in_timed   = (state == ST_SEND) | (state == ST_ACK) | (state == ST_WAIT_IDLE);
  assign timed_out  = in_timed & (cyc_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      dat_oe_q    <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      // Timeout is checked before the fall handling so it wins a same-cycle tie.
      if (timed_out) begin
        dat_oe_q    <= 1'b0;
        timeout_err <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state    <= ST_INHIBIT;
              cyc_cnt  <= '0;
              bit_cnt  <= '0;
              shift_q  <= {odd_parity(tx_data), tx_data};
              dat_oe_q <= 1'b0;
            end
          end
          ST_INHIBIT: begin
            if (cyc_cnt == INH_LAST) begin
              state    <= ST_REQ;
              cyc_cnt  <= '0;
              dat_oe_q <= 1'b1;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          ST_REQ: begin
            if (cyc_cnt == SETUP_LAST) begin
              state   <= ST_SEND;
              cyc_cnt <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          ST_SEND: begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (clk_fall) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == STOP_FALL) begin
                dat_oe_q <= 1'b0;
                state    <= ST_ACK;
              end else begin
                dat_oe_q <= ~shift_q[0];
                shift_q  <= {1'b0, shift_q[8:1]};
              end
            end
          end
          ST_ACK: begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (clk_fall) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (dat_sync) begin
                ack_err <= 1'b1;
                state   <= ST_IDLE;
              end else begin
                state <= ST_WAIT_IDLE;
              end
            end
          end
          ST_WAIT_IDLE: begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (clk_filt && dat_sync) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: behavioural PS/2 device clocks the frame, samples data while clock high,
// and answers ACK/NACK; sent bytes are scoreboarded against what the device captured.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 60;
  localparam int SETP = 6;
  localparam int TO   = 2000;
  localparam int FILT = 4;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SETP),
    .TIMEOUT_CYCLES (TO),
    .FILT_LEN       (FILT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_dat_in  (ps2_dat_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_dat_oe  (ps2_dat_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout_err (timeout_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_ack = 0, n_to = 0, n_inh = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (done) n_done++;
    if (ack_err) n_ack++;
    if (timeout_err) n_to++;
    if (ps2_clk_oe && !ps2_dat_oe) n_inh++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit push);
    @(negedge clk);
    check("ready_before_send", 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    if (push) exp_q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: waits for host request, then clocks out falls 1..11.
  // stop_at>0 returns in the low phase of that fall without finishing the frame.
  task automatic dev_frame(input bit nack, input int stop_at);
    logic [9:0] bits;
    logic [7:0] e;
    int n;
    bits = '0;
    n = 0;
    while (!(busy && ps2_clk_line && !ps2_dat_line) && n < INH + SETP + 100) begin
      @(negedge clk);
      n++;
    end
    check("dev_req_seen", 32'(n < INH + SETP + 100), 1);
    repeat (20) @(negedge clk);
    for (int k = 1; k <= FRAME_BITS; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k == stop_at) return;
      dev_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      if (k <= 10) bits[k-1] = ps2_dat_line;
      if (k == 10 && !nack) dev_dat = 1'b0;
      repeat (HALF / 2) @(negedge clk);
    end
    dev_dat = 1'b1;
    check("sb_nonempty", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dev_byte", 32'(bits[7:0]), 32'(e));
      check("dev_parity", 32'(bits[8]), 32'(~^e));
      check("dev_stop", 32'(bits[9]), 1);
    end
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (n_done == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", 32'(n_done - base), 1);
  endtask

  initial begin
    int d0, a0, t0, i0, n;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("rst_pulses", {29'd0, busy, done, ack_err, timeout_err}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Normal ACKed frames: parity 1, 0, 1.
    for (int t = 0; t < 3; t++) begin
      logic [7:0] b;
      b = (t == 0) ? CMD_SET_LED : (t == 1) ? 8'h01 : 8'h00;
      d0 = n_done; a0 = n_ack; t0 = n_to;
      send(b, 1'b1);
      dev_frame(1'b0, 0);
      wait_done(d0);
      check("no_err_pulses", 32'((n_ack - a0) + (n_to - t0)), 0);
      repeat (10) @(negedge clk);
    end

    // NACK: device leaves data high at fall 11.
    d0 = n_done;
    send(CMD_RESET, 1'b1);
    fork
      dev_frame(1'b1, 0);
      begin
        n = 0;
        while (!ack_err && n < 2000) begin
          @(negedge clk);
          n++;
        end
        check("ack_err_seen", 32'(ack_err), 1);
        check("nack_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        check("nack_ready_during_pulse", 32'(tx_ready), 0);
        @(negedge clk);
        check("nack_ready_after", 32'(tx_ready), 1);
      end
    join
    check("nack_no_done", 32'(n_done - d0), 0);
    repeat (10) @(negedge clk);

    // Silent device: timeout measured from REQ exit.
    d0 = n_done;
    send(8'h11, 1'b0);
    n = 0;
    while (!(busy && !ps2_clk_oe) && n < INH + SETP + 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!timeout_err && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO));
    check("timeout_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("timeout_no_done", 32'(n_done - d0), 0);
    repeat (10) @(negedge clk);

    // Reset mid-frame, after fall 5 (bit 4 of 0xA5 is 0, so data is being pulled low).
    send(8'hA5, 1'b0);
    dev_frame(1'b0, 5);
    check("pre_rst_dat_oe", 32'(ps2_dat_oe), 1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    check("rst_mid_busy", 32'(busy), 0);
    dev_clk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {30'd0, tx_ready, busy}, 32'b10);

    // Request while busy is dropped; INHIBIT length measured.
    d0 = n_done;
    i0 = n_inh;
    send(8'h3C, 1'b1);
    fork
      dev_frame(1'b0, 0);
      begin
        n = 0;
        while (!(busy && !ps2_clk_oe) && n < INH + SETP + 100) begin
          @(negedge clk);
          n++;
        end
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (300) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_done(d0);
    n = n_inh - i0;
    check("inhibit_len", 32'(n >= INH - 1 && n <= INH + 1), 1);
    repeat (50) @(negedge clk);
    check("busy_req_dropped", 32'(busy), 0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
